// File: rtl/io_loopback_pkg.sv
// Shared types and constants for the pad-ring loopback test core.
package io_loopback_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    DELAY  = 2'd1,
    COUNT  = 2'd2,
    PRBS   = 2'd3
  } mode_e;

  localparam int unsigned LFSR_W       = 16;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Right-shifting Fibonacci step; LFSR_TAPS is MSB-first, so tap i reads bit 15-i.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < int'(LFSR_W); i++) begin
      if (LFSR_TAPS[i]) fb = fb ^ l[int'(LFSR_W) - 1 - i];
    end
    return {fb, l[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/io_sync.sv
// Parametrised multi-stage synchroniser for asynchronous pad inputs.
module io_sync #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/io_loopback_core.sv
// Pad-ring test core: synchronised ui pads drive uo pads in bypass, delay,
// count or PRBS mode; every captured mode change inserts one blank cycle.
module io_loopback_core
  import io_loopback_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] SEED        = DEFAULT_SEED
) (
  input  logic             io_clock,
  input  logic             io_reset_n,
  input  logic [WIDTH-1:0] ui_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] uo_o,
  output logic [1:0]       mode_o
);

  logic [WIDTH-1:0]  ui_s;
  logic [1:0]        mode_sync;
  mode_e             mode_s;
  mode_e             mode_q, mode_d;
  logic [WIDTH-1:0]  uo_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  dl_q [DEPTH];
  logic [WIDTH-1:0]  dl_d [DEPTH];
  logic              blank_c;

  io_sync #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync_ui (
    .clk   (io_clock),
    .rst_n (io_reset_n),
    .d     (ui_i),
    .q     (ui_s)
  );

  io_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync_mode (
    .clk   (io_clock),
    .rst_n (io_reset_n),
    .d     (mode_i),
    .q     (mode_sync)
  );

  assign mode_s  = mode_e'(mode_sync);
  assign blank_c = (mode_s != mode_q);

  // Next-state logic: the blank cycle overrides every mode action.
  always_comb begin
    mode_d = mode_q;
    uo_d   = uo_o;
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    dl_d   = dl_q;

    if (blank_c) begin
      mode_d = mode_s;
      uo_d   = '0;
      cnt_d  = '0;
      lfsr_d = SEED;
      for (int k = 0; k < int'(DEPTH); k++) dl_d[k] = '0;
    end else begin
      case (mode_q)
        BYPASS: uo_d = ui_s;
        DELAY: begin
          uo_d    = dl_q[DEPTH-1];
          dl_d[0] = ui_s;
          for (int k = 1; k < int'(DEPTH); k++) dl_d[k] = dl_q[k-1];
        end
        COUNT: begin
          uo_d  = cnt_q;
          cnt_d = cnt_q + WIDTH'(1);
        end
        PRBS: begin
          uo_d   = lfsr_q[WIDTH-1:0];
          // An all-zero register would lock up; reload the seed instead.
          lfsr_d = (lfsr_q == '0) ? SEED : lfsr_step(lfsr_q);
        end
        default: uo_d = '0;
      endcase
    end
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      mode_q <= BYPASS;
      uo_o   <= '0;
      cnt_q  <= '0;
      lfsr_q <= SEED;
      for (int k = 0; k < int'(DEPTH); k++) dl_q[k] <= '0;
    end else begin
      mode_q <= mode_d;
      uo_o   <= uo_d;
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      dl_q   <= dl_d;
    end
  end

  assign mode_o = mode_q;

endmodule

// File: tb/tb_io_loopback_core.sv
// Self-checking bench: a 16-wide and a 4-wide core share stimulus and are
// compared against a queue-based reference model each cycle.
module tb_io_loopback_core;

  localparam int          S    = 2;
  localparam int          D    = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ui;
  logic [1:0]  mode;
  logic [15:0] uo;
  logic [1:0]  mode_o;
  logic [3:0]  uo_n;
  logic [1:0]  mode_o_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_loopback_core #(.WIDTH(16), .DEPTH(D), .SYNC_STAGES(S), .SEED(SEED)) dut (
    .io_clock   (clk),
    .io_reset_n (rst_n),
    .ui_i       (ui),
    .mode_i     (mode),
    .uo_o       (uo),
    .mode_o     (mode_o)
  );

  io_loopback_core #(.WIDTH(4), .DEPTH(D), .SYNC_STAGES(S), .SEED(SEED)) dut_n (
    .io_clock   (clk),
    .io_reset_n (rst_n),
    .ui_i       (ui[3:0]),
    .mode_i     (mode),
    .uo_o       (uo_n),
    .mode_o     (mode_o_n)
  );

  // Reference model: input pipelines, delay-line queue, plain counter and LFSR.
  logic [15:0] pu [S];
  logic [1:0]  pm [S];
  logic [1:0]  m_mode;
  logic [15:0] m_out;
  int unsigned m_cnt;
  logic [15:0] m_lfsr;
  logic [15:0] dq [$];

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      pu[i] = '0;
      pm[i] = '0;
    end
    m_mode = 2'd0;
    m_out  = '0;
    m_cnt  = 0;
    m_lfsr = SEED;
    dq     = {};
    repeat (D) dq.push_back(16'h0);
  endtask

  task automatic model_edge();
    logic [15:0] us;
    logic [1:0]  ms;
    us = pu[S-1];
    ms = pm[S-1];
    if (ms != m_mode) begin
      m_mode = ms;
      m_out  = '0;
      m_cnt  = 0;
      m_lfsr = SEED;
      for (int i = 0; i < D; i++) dq[i] = '0;
    end else begin
      case (m_mode)
        2'd0: m_out = us;
        2'd1: begin
          m_out = dq[D-1];
          dq.push_front(us);
          void'(dq.pop_back());
        end
        2'd2: begin
          m_out = m_cnt[15:0];
          m_cnt = (m_cnt + 1) % 65536;
        end
        default: begin
          m_out = m_lfsr;
          if (m_lfsr == 16'h0) m_lfsr = SEED;
          else m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
      endcase
    end
    for (int i = S - 1; i > 0; i--) begin
      pu[i] = pu[i-1];
      pm[i] = pm[i-1];
    end
    pu[0] = ui;
    pm[0] = mode;
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (uo === m_out) else begin
      errors++;
      $error("FAIL %s uo_o observed %h expected %h", tag, uo, m_out);
    end
    checks++;
    assert (mode_o === m_mode) else begin
      errors++;
      $error("FAIL %s mode_o observed %0d expected %0d", tag, mode_o, m_mode);
    end
    checks++;
    assert (uo_n === m_out[3:0]) else begin
      errors++;
      $error("FAIL %s uo_o(w4) observed %h expected %h", tag, uo_n, m_out[3:0]);
    end
    checks++;
    assert (mode_o_n === m_mode) else begin
      errors++;
      $error("FAIL %s mode_o(w4) observed %0d expected %0d", tag, mode_o_n, m_mode);
    end
  endtask

  task automatic expect_uo(input string tag, input logic [15:0] want);
    checks++;
    assert (uo === want) else begin
      errors++;
      $error("FAIL %s uo_o observed %h expected %h", tag, uo, want);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, sample 1 time unit later.
  task automatic cyc(input logic [15:0] u, input logic [1:0] md, input logic r, input string tag);
    @(negedge clk);
    ui    = u;
    mode  = md;
    rst_n = r;
    if (!r) begin
      #1;
      model_reset();
      check_all({tag, "_async"});
    end
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check_all(tag);
  endtask

  int          hit_at;
  int          hits;
  int          leaks;
  logic [1:0]  rmode;

  initial begin
    rst_n = 1'b0;
    ui    = 16'hFFFF;
    mode  = 2'd3;
    model_reset();

    // Reset held with active-looking inputs, then release into a PRBS blank.
    repeat (3) cyc(16'hFFFF, 2'd3, 1'b0, "reset_hold");
    repeat (3) cyc(16'hFFFF, 2'd3, 1'b1, "reset_release");
    cyc(16'hFFFF, 2'd3, 1'b1, "prbs_first");
    expect_uo("prbs_seed", 16'hACE1);
    cyc(16'hFFFF, 2'd3, 1'b1, "prbs_second");
    expect_uo("prbs_step", 16'h5670);

    // Bypass step latency.
    repeat (6) cyc(16'h0000, 2'd0, 1'b1, "to_bypass");
    cyc(16'hA5A5, 2'd0, 1'b1, "byp_e1");
    expect_uo("byp_edge1", 16'h0000);
    cyc(16'hA5A5, 2'd0, 1'b1, "byp_e2");
    expect_uo("byp_edge2", 16'h0000);
    cyc(16'hA5A5, 2'd0, 1'b1, "byp_e3");
    expect_uo("byp_edge3", 16'hA5A5);

    // Delay single-cycle pulse latency.
    repeat (8) cyc(16'h0000, 2'd1, 1'b1, "to_delay");
    cyc(16'h0001, 2'd1, 1'b1, "dly_pulse");
    hit_at = -1;
    hits   = 0;
    for (int e = 2; e <= 13; e++) begin
      cyc(16'h0000, 2'd1, 1'b1, "dly_tail");
      if (uo == 16'h0001) begin
        hits++;
        if (hit_at < 0) hit_at = e;
      end
    end
    checks++;
    assert (hit_at == 7 && hits == 1) else begin
      errors++;
      $error("FAIL dly_latency edge %0d count %0d expected edge 7 count 1", hit_at, hits);
    end

    // Count long enough for the 4-wide instance to wrap, then leave mid-count.
    repeat (40) cyc(16'($urandom), 2'd2, 1'b1, "count");
    repeat (6) cyc(16'($urandom), 2'd0, 1'b1, "count_exit");

    // PRBS run with noisy ui.
    repeat (80) cyc(16'($urandom), 2'd3, 1'b1, "prbs_run");

    // Random mode hopping, including back-to-back changes.
    rmode = 2'd0;
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) rmode = 2'($urandom_range(0, 3));
      cyc(16'($urandom), rmode, 1'b1, "random");
    end

    // Reset while the delay line is full of a marker value.
    repeat (12) cyc(16'h1234, 2'd1, 1'b1, "fill");
    expect_uo("fill_full", 16'h1234);
    cyc(16'h1234, 2'd1, 1'b0, "rst_mid");
    cyc(16'h0000, 2'd1, 1'b0, "rst_mid_hold");
    leaks = 0;
    repeat (20) begin
      cyc(16'h0000, 2'd1, 1'b1, "after_rst");
      if (uo == 16'h1234) leaks++;
    end
    checks++;
    assert (leaks == 0) else begin
      errors++;
      $error("FAIL rst_flush marker seen %0d times expected 0", leaks);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
